sha256_round_engine: RTL and testbench
======================================

Name: sha256_round_engine

Overview:
- SHA-256 compression core. Consumes the 16x128-bit K-constant RAM through its second port (s2) and processes one 512-bit padded message block per start.
- Runs 64 rounds, one per clock, and adds the result into the chaining state.
- Sits directly downstream of the K RAM and upstream of the HPS-facing digest registers.

Parameters:
- K_AW, 4: K RAM address width; 16 lines x 4 constants each.
- K_DW, 128: K RAM data width; four 32-bit K words per line.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin a block; accepted only while ready=1
- block_data  in  512  padded block, big-endian; W0 = [511:480], W15 = [31:0]
- chain  in  1  (SHA256_CHAIN_EN only) 1 = continue from current digest, 0 = start from the IV
- ready  out  1  high in IDLE
- busy  out  1  high in PREFETCH, ROUND and FINAL
- done  out  1  one-cycle pulse; digest valid
- digest  out  256  H0..H7, with H0 = [255:224]
- k_address  out  4  K RAM port-2 address
- k_chipselect  out  1  high while busy
- k_clken  out  1  tied to 1
- k_readdata  in  128  K RAM port-2 data; the RAM registers the address and leaves q unregistered, so data appears 1 cycle after address

Behaviour:
- Reset (synchronous) values: state=IDLE, done=0, busy=0, ready=1, digest=0, k_address=0, k_chipselect=0, round counter=0.
- K layout: K[4i+j] is k_readdata[32j+31:32j] of line i.
- FSM states: IDLE, PREFETCH, ROUND, FINAL.
- IDLE:
  - On start, latch block_data into the 16-word W window.
  - Load a..h from the IV (6a09e667 ... 5be0cd19), or from digest when chain=1.
  - Move to PREFETCH.
  - start while busy is ignored, with no latching and no effect.
- PREFETCH (1 cycle): k_address=0. Then ROUND with t=0.
- ROUND (64 cycles, t=0..63):
  - k_address = ((t+1)>>2) mod 16, combinational from t.
  - Round t uses lane t&3 of k_readdata directly; the line was addressed in the previous cycle. No K buffer.
  - W window: W[t] is window[0]. Shift in W[t+16] = s1(W[t+14]) + W[t+9] + s0(W[t+1]) + W[t], all mod 2^32.
  - Standard round: T1 = h + S1(e) + Ch(e,f,g) + K[t] + W[t]; T2 = S0(a) + Maj(a,b,c); all adds truncate to 32 bits.
  - After t=63, go to FINAL.
- FINAL (1 cycle): compute Hi_new = Hi_base + working var, mod 2^32, where Hi_base is the value latched at start.
- At the next edge:
  - digest is registered.
  - done=1 for exactly one cycle.
  - state=IDLE, ready=1.
- Latency: if start is sampled at edge E, done and digest are valid after edge E+66.
- start in the cycle where done=1 is accepted; back-to-back blocks run at a 67-cycle period.
- digest holds its value until the next FINAL or reset. It is never cleared by start.
- reset mid-operation: abort immediately, apply reset values (digest=0), drop k_chipselect, and discard any K data in flight.
- X-safety: k_readdata is ignored outside ROUND.

Optional Feature:
- Macro: SHA256_CHAIN_EN.
- Defined: the chain port exists and enables multi-block messages by chaining from digest.
- Undefined: no chain port; every block starts from the IV, so only single-block messages are supported. The digest register remains.

Decomposition:
- Package sha256_pkg:
  - IV constant array
  - state enum (IDLE/PREFETCH/ROUND/FINAL)
  - word_t (32-bit) typedef
  - functions: rotr, Ch, Maj, S0, S1, s0, s1
- Sub-module sha256_msg_sched holds the 16-word W window:
  - load: input 512, shift: input 1, w_t: output 32
  - single-cycle shift/expand, no internal FSM

Test Plan:
- "abc" single padded block (0x61626380, zeros, length word 0x18), IV → after edge E+66: digest = ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad, done=1 for one cycle.
- Empty message block (0x80000000, zeros, length 0) → digest = e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855.
- SHA256_CHAIN_EN, two-block message "abcdbcdecdef...nopq" (448-bit), second start with chain=1 issued in the done cycle → digest = 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1; second done 67 cycles after the first.
- K fetch check: monitor k_address during ROUND → 0 at PREFETCH, then steps to 1,2,...,15 exactly at t=3,7,...,59. Value at t=63 is don't-care (0). k_chipselect is high only while busy.
- start pulsed at round t=20 → ignored; digest equals the "abc" result and there is no extra done.
- reset asserted at round t=30 → next cycle: ready=1, busy=0, digest=0, done=0. A following "abc" run produces the correct digest.

Source files
------------

// File: rtl/sha256_pkg.sv
// ----------------------------------------------------------------------------
// sha256_pkg : shared types, IV constants and round functions for SHA-256.
// Revision   : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package sha256_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREFETCH = 2'd1,
    ROUND    = 2'd2,
    FINAL    = 2'd3
  } state_t;

  localparam word_t IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic word_t ch(input word_t e, input word_t f, input word_t g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic word_t maj(input word_t a, input word_t b, input word_t c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

  function automatic word_t S0(input word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic word_t S1(input word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic word_t s0(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t s1(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sha256_msg_sched.sv
// ----------------------------------------------------------------------------
// sha256_msg_sched : 16-word sliding W window; window[0] is W[t].
// Revision         : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sha256_msg_sched
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         load_en,
  input  logic [511:0] load,
  input  logic         shift,
  output word_t        w_t
);

  word_t window [16];
  word_t w_next;

  // W[t+16] from the words currently at offsets 14, 9, 1 and 0.
  assign w_next = s1(window[14]) + window[9] + s0(window[1]) + window[0];
  assign w_t    = window[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) window[i] <= '0;
    end else if (load_en) begin
      for (int i = 0; i < 16; i++) window[i] <= load[511 - 32*i -: 32];
    end else if (shift) begin
      for (int i = 0; i < 15; i++) window[i] <= window[i+1];
      window[15] <= w_next;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sha256_round_engine.sv
// ----------------------------------------------------------------------------
// sha256_round_engine : one SHA-256 block per start, 64 rounds at one per clk.
// Optional macro SHA256_CHAIN_EN adds the chain port for multi-block messages.
// Revision            : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sha256_round_engine
  import sha256_pkg::*;
#(
  parameter int K_AW = 4,
  parameter int K_DW = 128
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [511:0]    block_data,
`ifdef SHA256_CHAIN_EN
  input  logic            chain,
`endif
  output logic            ready,
  output logic            busy,
  output logic            done,
  output logic [255:0]    digest,
  output logic [K_AW-1:0] k_address,
  output logic            k_chipselect,
  output logic            k_clken,
  input  logic [K_DW-1:0] k_readdata
);

  state_t state, state_next;
  logic [5:0] t;
  logic [6:0] t_plus1;
  word_t v     [8];
  word_t hbase [8];
  word_t w_t, k_t, t1, t2;
  logic  accept;
  logic  use_chain;

`ifdef SHA256_CHAIN_EN
  assign use_chain = chain;
`else
  assign use_chain = 1'b0;
`endif

  assign accept       = start && (state == IDLE);
  assign ready        = (state == IDLE);
  assign busy         = (state != IDLE);
  assign k_chipselect = busy;
  assign k_clken      = 1'b1;

  // The RAM latches this address now, so it fetches the line round t+1 needs.
  assign t_plus1   = {1'b0, t} + 7'd1;
  assign k_address = (state == ROUND) ? t_plus1[2 +: K_AW] : '0;

  assign k_t = k_readdata[{t[1:0], 5'd0} +: 32];
  assign t1  = v[7] + S1(v[4]) + ch(v[4], v[5], v[6]) + k_t + w_t;
  assign t2  = S0(v[0]) + maj(v[0], v[1], v[2]);

  sha256_msg_sched u_msg_sched (
    .clk     (clk),
    .reset   (reset),
    .load_en (accept),
    .load    (block_data),
    .shift   (state == ROUND),
    .w_t     (w_t)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (start) state_next = PREFETCH;
      PREFETCH: state_next = ROUND;
      ROUND:    if (t == 6'd63) state_next = FINAL;
      FINAL:    state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      t      <= '0;
      done   <= 1'b0;
      digest <= '0;
      for (int i = 0; i < 8; i++) begin
        v[i]     <= '0;
        hbase[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            for (int i = 0; i < 8; i++) begin
              v[i]     <= use_chain ? digest[255 - 32*i -: 32] : IV[i];
              hbase[i] <= use_chain ? digest[255 - 32*i -: 32] : IV[i];
            end
          end
        end
        PREFETCH: t <= '0;
        ROUND: begin
          t    <= t + 6'd1;
          v[0] <= t1 + t2;
          v[1] <= v[0];
          v[2] <= v[1];
          v[3] <= v[2];
          v[4] <= v[3] + t1;
          v[5] <= v[4];
          v[6] <= v[5];
          v[7] <= v[6];
        end
        FINAL: begin
          done <= 1'b1;
          for (int i = 0; i < 8; i++)
            digest[255 - 32*i -: 32] <= hbase[i] + v[i];
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sha256_round_engine.sv
// ----------------------------------------------------------------------------
// tb_sha256_round_engine : directed known-answer bench with a K RAM model.
// Revision               : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_sha256_round_engine;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'd0, 32'h00000018};
  localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'd0};
  localparam logic [255:0] DG_ABC    = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] DG_EMPTY  = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [511:0] block_data;
  logic         ready, busy, done, k_chipselect, k_clken;
  logic [255:0] digest;
  logic [3:0]   k_address;
  logic [127:0] k_readdata;
  logic [3:0]   k_addr_q;
`ifdef SHA256_CHAIN_EN
  logic         chain;
`endif

  int total = 0;
  int bad   = 0;

  sha256_round_engine #(.K_AW(4), .K_DW(128)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .block_data   (block_data),
`ifdef SHA256_CHAIN_EN
    .chain        (chain),
`endif
    .ready        (ready),
    .busy         (busy),
    .done         (done),
    .digest       (digest),
    .k_address    (k_address),
    .k_chipselect (k_chipselect),
    .k_clken      (k_clken),
    .k_readdata   (k_readdata)
  );

  always #5 clk = ~clk;

  // K RAM port 2: registered address, unregistered q.
  always @(posedge clk) if (k_clken) k_addr_q <= k_address;
  always_comb begin
    k_readdata = '0;
    for (int j = 0; j < 4; j++)
      k_readdata[32*j +: 32] = KT[{k_addr_q, 2'(j)}];
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_block(input logic [511:0] blk);
    block_data = blk;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  // Runs one block from start to done; returns in the done cycle.
  task automatic run_block(input logic [511:0] blk, input logic [255:0] exp,
                           input bit check_dg, input bit poke_t20);
    int cycles;
    start_block(blk);
    cycles = 0;
    check("prefetch_kaddr", 256'(k_address), 256'd0);
    check("prefetch_cs", 256'(k_chipselect), 256'd1);
    while (done !== 1'b1 && cycles < 80) begin
      tick();
      cycles++;
      start = 1'b0;
      if (cycles <= 64) begin
        check("round_kaddr", 256'(k_address), 256'((cycles >> 2) & 15));
        check("round_cs", 256'(k_chipselect), 256'd1);
      end
      if (poke_t20 && cycles == 21) begin
        block_data = BLK_EMPTY;
        start      = 1'b1;
      end
    end
    check("latency", 256'(cycles), 256'd66);
    check("done_ready", 256'(ready), 256'd1);
    check("done_cs_low", 256'(k_chipselect), 256'd0);
    if (check_dg) check("digest", digest, exp);
  endtask

  initial begin
    int extra;
    reset      = 1'b1;
    start      = 1'b0;
    block_data = '0;
`ifdef SHA256_CHAIN_EN
    chain      = 1'b0;
`endif
    tick();
    tick();
    check("rst_ready", 256'(ready), 256'd1);
    check("rst_busy", 256'(busy), 256'd0);
    check("rst_done", 256'(done), 256'd0);
    check("rst_digest", digest, 256'd0);
    check("rst_kaddr", 256'(k_address), 256'd0);
    check("rst_cs", 256'(k_chipselect), 256'd0);
    check("rst_clken", 256'(k_clken), 256'd1);
    reset = 1'b0;
    tick();

    run_block(BLK_ABC, DG_ABC, 1'b1, 1'b0);
    tick();
    check("done_one_cycle", 256'(done), 256'd0);
    check("digest_hold", digest, DG_ABC);

    run_block(BLK_EMPTY, DG_EMPTY, 1'b1, 1'b0);
    tick();

    // Back-to-back: next start issued in the done cycle.
    run_block(BLK_ABC, DG_ABC, 1'b1, 1'b0);
    run_block(BLK_EMPTY, DG_EMPTY, 1'b1, 1'b0);
    tick();

    // A start during round 20 must be ignored entirely.
    run_block(BLK_ABC, DG_ABC, 1'b1, 1'b1);
    extra = 0;
    for (int i = 0; i < 72; i++) begin
      tick();
      if (done === 1'b1) extra++;
    end
    check("no_extra_done", 256'(extra), 256'd0);
    check("idle_after_ignore", 256'(ready), 256'd1);

    // Reset at round 30.
    start_block(BLK_EMPTY);
    repeat (31) tick();
    check("pre_reset_busy", 256'(busy), 256'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_ready", 256'(ready), 256'd1);
    check("mid_rst_busy", 256'(busy), 256'd0);
    check("mid_rst_digest", digest, 256'd0);
    check("mid_rst_done", 256'(done), 256'd0);
    check("mid_rst_cs", 256'(k_chipselect), 256'd0);
    tick();
    run_block(BLK_ABC, DG_ABC, 1'b1, 1'b0);
    tick();

`ifdef SHA256_CHAIN_EN
    chain = 1'b0;
    run_block({32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
               32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
               32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
               32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000},
              256'h85e655d6417a17953363376a624cde5c76e09589cac5f811cc4b32c1f20e533a,
              1'b1, 1'b0);
    chain = 1'b1;
    run_block({480'd0, 32'h000001c0},
              256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1,
              1'b1, 1'b0);
    chain = 1'b0;
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
